// File: rtl/selector_ajuste_rep.sv
// Routes the hour/minute adjust buttons to one of N_CANALES targets, with debounce,
// hold-to-repeat and a mode button that cycles the selected target.

module selector_ajuste_rep_deb #(
    parameter int CNT_W      = 20,
    parameter int DEB_CICLOS = 50000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic estado_o
);
    localparam logic [CNT_W-1:0] DEB_TC = CNT_W'(DEB_CICLOS - 1);

    logic             sync1_q, sync2_q;
    logic             est_q, est_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        est_d = est_q;
        cnt_d = '0;
        if (sync2_q != est_q) begin
            if (cnt_q == DEB_TC) begin
                est_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            est_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            est_q   <= est_d;
            cnt_q   <= cnt_d;
        end
    end

    assign estado_o = est_q;
endmodule

// Hold-to-repeat sequencer for one adjust button.
//   state   | meaning
//   REPOSO  | released, waiting for a press
//   ESPERA  | first pulse sent, counting the initial hold delay
//   REPITE  | auto-repeating every REP_PERIODO cycles
//   BLOQUEO | target changed while held, silent until release
module selector_ajuste_rep_fsm #(
    parameter int CNT_W       = 20,
    parameter int REP_RETARDO = 500000,
    parameter int REP_PERIODO = 100000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic pulsado_i,
    input  logic flanco_i,
    input  logic cambio_i,
    output logic pulso_o
);
    localparam logic [1:0] REPOSO  = 2'd0;
    localparam logic [1:0] ESPERA  = 2'd1;
    localparam logic [1:0] REPITE  = 2'd2;
    localparam logic [1:0] BLOQUEO = 2'd3;

    localparam bit               REP_ON    = (REP_RETARDO > 0);
    localparam logic [CNT_W-1:0] RET_CARGA = REP_ON ? CNT_W'(REP_RETARDO - 1) : '0;
    localparam logic [CNT_W-1:0] PER_CARGA = CNT_W'(REP_PERIODO - 1);

    logic [1:0]       estado_q, estado_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        pulso_o  = 1'b0;
        case (estado_q)
            REPOSO: begin
                if (flanco_i) begin
                    pulso_o  = 1'b1;
                    estado_d = ESPERA;
                    cnt_d    = RET_CARGA;
                end
            end
            ESPERA: begin
                if (!pulsado_i) begin
                    estado_d = REPOSO;
                end else if (cambio_i) begin
                    estado_d = BLOQUEO;
                end else if (REP_ON) begin
                    if (cnt_q == '0) begin
                        pulso_o  = 1'b1;
                        estado_d = REPITE;
                        cnt_d    = PER_CARGA;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            REPITE: begin
                if (!pulsado_i) begin
                    estado_d = REPOSO;
                end else if (cambio_i) begin
                    estado_d = BLOQUEO;
                end else if (cnt_q == '0) begin
                    pulso_o = 1'b1;
                    cnt_d   = PER_CARGA;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            BLOQUEO: begin
                if (!pulsado_i) begin
                    estado_d = REPOSO;
                end
            end
            default: estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            estado_q <= REPOSO;
            cnt_q    <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

module selector_ajuste_rep #(
    parameter int N_CANALES   = 2,
    parameter int SEL_W       = 1,
    parameter int CNT_W       = 20,
    parameter int DEB_CICLOS  = 50000,
    parameter int REP_RETARDO = 500000,
    parameter int REP_PERIODO = 100000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 puls_hora,
    input  logic                 puls_minuto,
    input  logic                 puls_modo,
    output logic [N_CANALES-1:0] hora_pulso,
    output logic [N_CANALES-1:0] minuto_pulso,
    output logic [SEL_W-1:0]     canal_sel
);
    localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_CANALES - 1);

    // bit 0 = hour, bit 1 = minute, bit 2 = mode
    logic [2:0] raw, est, est_prev_q, flanco;

    logic                 pulso_h, pulso_m, cambio;
    logic [SEL_W-1:0]     canal_sel_q, canal_sel_d, sel_prev_q;
    logic [N_CANALES-1:0] hora_q, hora_d, minuto_q, minuto_d;

    assign raw = {puls_modo, puls_minuto, puls_hora};

    selector_ajuste_rep_deb #(.CNT_W(CNT_W), .DEB_CICLOS(DEB_CICLOS)) u_deb_hora (
        .clk_i(clk), .rst_n_i(rst_n), .raw_i(raw[0]), .estado_o(est[0])
    );
    selector_ajuste_rep_deb #(.CNT_W(CNT_W), .DEB_CICLOS(DEB_CICLOS)) u_deb_minuto (
        .clk_i(clk), .rst_n_i(rst_n), .raw_i(raw[1]), .estado_o(est[1])
    );
    selector_ajuste_rep_deb #(.CNT_W(CNT_W), .DEB_CICLOS(DEB_CICLOS)) u_deb_modo (
        .clk_i(clk), .rst_n_i(rst_n), .raw_i(raw[2]), .estado_o(est[2])
    );

    assign flanco = est & ~est_prev_q;
    // Held buttons are blocked the cycle after canal_sel moves, so a pulse
    // coinciding with the mode press still lands on the old target.
    assign cambio = (canal_sel_q != sel_prev_q);

    selector_ajuste_rep_fsm #(
        .CNT_W(CNT_W), .REP_RETARDO(REP_RETARDO), .REP_PERIODO(REP_PERIODO)
    ) u_rep_hora (
        .clk_i(clk), .rst_n_i(rst_n), .pulsado_i(est[0]), .flanco_i(flanco[0]),
        .cambio_i(cambio), .pulso_o(pulso_h)
    );
    selector_ajuste_rep_fsm #(
        .CNT_W(CNT_W), .REP_RETARDO(REP_RETARDO), .REP_PERIODO(REP_PERIODO)
    ) u_rep_minuto (
        .clk_i(clk), .rst_n_i(rst_n), .pulsado_i(est[1]), .flanco_i(flanco[1]),
        .cambio_i(cambio), .pulso_o(pulso_m)
    );

    always_comb begin
        canal_sel_d = canal_sel_q;
        if (flanco[2]) begin
            if (canal_sel_q >= SEL_MAX) begin
                canal_sel_d = '0;
            end else begin
                canal_sel_d = canal_sel_q + 1'b1;
            end
        end
    end

    always_comb begin
        hora_d   = '0;
        minuto_d = '0;
        for (int i = 0; i < N_CANALES; i++) begin
            hora_d[i]   = pulso_h & (canal_sel_q == SEL_W'(i));
            minuto_d[i] = pulso_m & (canal_sel_q == SEL_W'(i));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            est_prev_q  <= '0;
            canal_sel_q <= '0;
            sel_prev_q  <= '0;
            hora_q      <= '0;
            minuto_q    <= '0;
        end else begin
            est_prev_q  <= est;
            canal_sel_q <= canal_sel_d;
            sel_prev_q  <= canal_sel_q;
            hora_q      <= hora_d;
            minuto_q    <= minuto_d;
        end
    end

    assign hora_pulso   = hora_q;
    assign minuto_pulso = minuto_q;
    assign canal_sel    = canal_sel_q;
endmodule

// File: tb/tb_selector_ajuste_rep.sv
// Directed bench for selector_ajuste_rep: N_CANALES=3, DEB_CICLOS=4,
// REP_RETARDO=10, REP_PERIODO=3; pulses are logged with their cycle number.
module tb_selector_ajuste_rep;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       puls_hora = 1'b0, puls_minuto = 1'b0, puls_modo = 1'b0;
    logic [2:0] hora_pulso, minuto_pulso;
    logic [1:0] canal_sel;

    int         ciclo = 0, t0 = 0;
    int         total = 0, pasados = 0;
    int         hq_c[$], mq_c[$];
    logic [2:0] hq_v[$], mq_v[$];
    int         exp_rep[8] = '{7, 17, 20, 23, 26, 29, 32, 35};
    int         exp_h4[6]  = '{7, 17, 20, 23, 26, 29};

    selector_ajuste_rep #(
        .N_CANALES(3), .SEL_W(2), .CNT_W(20),
        .DEB_CICLOS(4), .REP_RETARDO(10), .REP_PERIODO(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .puls_hora(puls_hora), .puls_minuto(puls_minuto),
        .puls_modo(puls_modo), .hora_pulso(hora_pulso), .minuto_pulso(minuto_pulso),
        .canal_sel(canal_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) pasados++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ciclo++;
        if (hora_pulso != 3'b000) begin
            hq_c.push_back(ciclo);
            hq_v.push_back(hora_pulso);
        end
        if (minuto_pulso != 3'b000) begin
            mq_c.push_back(ciclo);
            mq_v.push_back(minuto_pulso);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic limpiar();
        hq_c.delete(); hq_v.delete(); mq_c.delete(); mq_v.delete();
        t0 = ciclo;
    endtask

    initial begin
        // 1: reset values, single hour press
        run(3);
        chk("rst_hora", int'(hora_pulso), 0);
        chk("rst_minuto", int'(minuto_pulso), 0);
        chk("rst_canal", int'(canal_sel), 0);
        rst_n = 1'b1;
        limpiar();
        puls_hora = 1'b1; run(8); puls_hora = 1'b0; run(12);
        chk("t1_hora_n", hq_c.size(), 1);
        chk("t1_hora_cyc", hq_c[0] - t0, 7);
        chk("t1_hora_val", int'(hq_v[0]), 1);
        chk("t1_minuto_n", mq_c.size(), 0);
        chk("t1_canal", int'(canal_sel), 0);

        // 2: bounce rejected, then minute hold-to-repeat
        limpiar();
        puls_minuto = 1'b1; run(2); puls_minuto = 1'b0; run(2);
        puls_minuto = 1'b1; run(2); puls_minuto = 1'b0; run(12);
        chk("t2_bounce_n", mq_c.size(), 0);
        limpiar();
        puls_minuto = 1'b1; run(30); puls_minuto = 1'b0; run(20);
        chk("t2_rep_n", mq_c.size(), 8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_rep_cyc%0d", i), mq_c[i] - t0, exp_rep[i]);
            chk($sformatf("t2_rep_val%0d", i), int'(mq_v[i]), 1);
        end
        chk("t2_hora_n", hq_c.size(), 0);

        // 3: cycle targets 1,2,0,1 then hour press lands on bit 1
        limpiar();
        puls_modo = 1'b1; run(8); puls_modo = 1'b0; run(8);
        chk("t3_sel_a", int'(canal_sel), 1);
        puls_modo = 1'b1; run(8); puls_modo = 1'b0; run(8);
        chk("t3_sel_b", int'(canal_sel), 2);
        puls_modo = 1'b1; run(8); puls_modo = 1'b0; run(8);
        chk("t3_sel_c", int'(canal_sel), 0);
        puls_modo = 1'b1; run(8); puls_modo = 1'b0; run(8);
        chk("t3_sel_d", int'(canal_sel), 1);
        chk("t3_no_pulse", hq_c.size() + mq_c.size(), 0);
        limpiar();
        puls_hora = 1'b1; run(8); puls_hora = 1'b0; run(12);
        chk("t3_hora_n", hq_c.size(), 1);
        chk("t3_hora_cyc", hq_c[0] - t0, 7);
        chk("t3_hora_val", int'(hq_v[0]), 2);

        // 4: target change while repeating blocks the held hour button
        limpiar();
        puls_hora = 1'b1; run(22);
        puls_modo = 1'b1; run(8); puls_modo = 1'b0;
        run(30);
        chk("t4_hora_n", hq_c.size(), 6);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t4_cyc%0d", i), hq_c[i] - t0, exp_h4[i]);
            chk($sformatf("t4_val%0d", i), int'(hq_v[i]), 2);
        end
        puls_hora = 1'b0; run(12);
        chk("t4_sel", int'(canal_sel), 2);
        limpiar();
        puls_hora = 1'b1; run(8); puls_hora = 1'b0; run(12);
        chk("t4_repress_n", hq_c.size(), 1);
        chk("t4_repress_cyc", hq_c[0] - t0, 7);
        chk("t4_repress_val", int'(hq_v[0]), 4);

        // 5: simultaneous hour and minute on target 2
        limpiar();
        puls_hora = 1'b1; puls_minuto = 1'b1; run(8);
        puls_hora = 1'b0; puls_minuto = 1'b0; run(12);
        chk("t5_hora_n", hq_c.size(), 1);
        chk("t5_minuto_n", mq_c.size(), 1);
        chk("t5_hora_cyc", hq_c[0] - t0, 7);
        chk("t5_minuto_cyc", mq_c[0] - t0, 7);
        chk("t5_hora_val", int'(hq_v[0]), 4);
        chk("t5_minuto_val", int'(mq_v[0]), 4);

        // 6: asynchronous reset mid-repeat, button held through release
        limpiar();
        puls_hora = 1'b1; run(23);
        chk("t6_pre_hora", int'(hora_pulso), 4);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_async_hora", int'(hora_pulso), 0);
        chk("t6_async_minuto", int'(minuto_pulso), 0);
        chk("t6_async_canal", int'(canal_sel), 0);
        run(2);
        rst_n = 1'b1;
        limpiar();
        run(12);
        chk("t6_after_n_ge1", int'(hq_c.size() >= 1), 1);
        chk("t6_after_cyc", hq_c[0] - t0, 7);
        chk("t6_after_val", int'(hq_v[0]), 1);
        puls_hora = 1'b0; run(12);

        $display("%0d/%0d checks passed", pasados, total);
        $finish;
    end
endmodule

// File: doc/selector_ajuste_rep.md
Name: selector_ajuste_rep

Overview:
Parametrised successor to the hour/minute pulse router of the alarm clock. It routes the two adjust buttons (hour, minute) to one of N_CANALES targets (clock, alarm, timer, ...). A third button cycles through the targets. Each button is synchronised, debounced and edge-detected, and hour/minute get hold-to-repeat, so downstream counters receive clean one-cycle increment pulses.

Parameters:
N_CANALES, 2, number of targets; must be ≥2.
SEL_W, 1, width of canal_sel; must satisfy 2^SEL_W ≥ N_CANALES.
CNT_W, 20, width of debounce and repeat counters.
DEB_CICLOS, 50000, consecutive stable cycles needed to accept a button change; must be ≥1.
REP_RETARDO, 500000, hold cycles after the first pulse before repeat starts; 0 disables repeat.
REP_PERIODO, 100000, cycles between repeat pulses; must be ≥1.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
puls_hora  in  1  raw hour button, active high, asynchronous
puls_minuto  in  1  raw minute button, active high, asynchronous
puls_modo  in  1  raw target-cycle button, active high, asynchronous
hora_pulso  out  N_CANALES  one-cycle hour increment; bit i = target i
minuto_pulso  out  N_CANALES  one-cycle minute increment; bit i = target i
canal_sel  out  SEL_W  currently selected target index

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All state is cleared on rst_n=0, regardless of clk.
- Reset values:
  - hora_pulso=0, minuto_pulso=0, canal_sel=0.
  - Synchronisers, debounced states and counters are 0, meaning "released".
  - Both repeat FSMs are in REPOSO.
- Synchroniser: each raw input passes through a 2-FF synchroniser.
- Debounce (per button):
  - The counter clears whenever the synced input equals the debounced state.
  - While the synced input differs, the counter increments.
  - When the counter reaches DEB_CICLOS-1 with the input still differing, the debounced state takes the new value and the counter clears.
- Edge detect: a rising edge of the debounced state is the press event. Latency from raw rising edge to output pulse is 2+DEB_CICLOS+1 cycles. All outputs are registered.
- Repeat FSM (independent instance for hour and for minute):
  - REPOSO: on press event, emit one pulse, go to ESPERA, load counter.
  - ESPERA: on release, go to REPOSO. If REP_RETARDO=0, stay in ESPERA until release. Otherwise, after REP_RETARDO cycles held, emit a pulse and go to REPITE.
  - REPITE: emit a pulse every REP_PERIODO cycles while held. On release, go to REPOSO and cancel any pending pulse.
  - BLOQUEO: entered from ESPERA or REPITE when canal_sel changes. No pulses are emitted. On release, go to REPOSO.
- Routing: a pulse is driven on bit canal_sel of hora_pulso / minuto_pulso. The outputs are one-hot or zero; bits ≥ N_CANALES are never driven.
- Target cycling:
  - A modo press event sets canal_sel to canal_sel+1, wrapping from N_CANALES-1 to 0.
  - modo has no repeat; holding it gives one step.
- Simultaneous events:
  - Hour and minute pulses in the same cycle are both driven on the same target.
  - A modo press in the same cycle as an hour/minute pulse: the pulse goes to the old target; canal_sel updates the next cycle; held buttons then enter BLOQUEO.
- Glitches: a bounce shorter than DEB_CICLOS cycles never changes the debounced state and produces no pulse.
- Reset mid-operation: outputs return to reset values immediately. A button held through reset deassertion is seen as a new press after the debounce latency.

Test Plan:
Bench parameters for all scenarios: N_CANALES=3, SEL_W=2, DEB_CICLOS=4, REP_RETARDO=10, REP_PERIODO=3.
1. Reset, then hold puls_hora high for 8 cycles → exactly one hora_pulso=3'b001 at cycle 7 after the raw edge; minuto_pulso stays 0; canal_sel=0.
2. puls_minuto bounces 1-0-1-0 with 2-cycle segments, then stays low → no pulse. Then hold it high for 30 cycles → pulses at +7, +17, +20, +23, +26, +29, …; none after release plus debounce latency.
3. Press puls_modo 4 times, each held 8 cycles with 8 cycles released → canal_sel goes 1, 2, 0, 1. A following hour press → hora_pulso=3'b010.
4. Hold puls_hora into REPITE, then press puls_modo → hour pulses stop once canal_sel changes, even though hour is still held. Release and re-press hour → one pulse on the new target bit.
5. Drive puls_hora and puls_minuto rising in the same cycle with canal_sel=2 → hora_pulso=minuto_pulso=3'b100 in the same cycle.
6. Assert rst_n=0 asynchronously mid-REPITE with canal_sel=2 → outputs and canal_sel are 0 without waiting for a clk edge. Keep hour held through reset release → first pulse 7 cycles later on bit 0.
